led_pwm_bank: RTL



---
 rtl/led_pwm_bank.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: multi-channel LED PWM driver with off / steady / blink / breathe modes.
// Latency: a config write reaches the pins at the next PWM wrap, within 2**PWM_BITS+1 cycles.
// Backpressure: none; every write strobe is accepted, and out-of-range channels are dropped.
//
// Ports:
//   clk      - system clock (100 MHz on the board)
//   rst      - synchronous reset, active-high; it overrides a write in the same cycle
//   wr_en    - one-cycle config write strobe
//   wr_addr  - channel index; indices >= NUM_LEDS are ignored
//   wr_data  - {mode[1:0], level[PWM_BITS-1:0]}; mode 00=off 01=pwm 10=blink 11=breathe
//   led      - registered LED drive, 1 = lit
//   pwm_wrap - one-cycle pulse, coincident with pwm_cnt = 0
//
// Optional build macro LED_GAMMA_EN: squares the requested duty, (d*d)>>PWM_BITS,
// before it is latched, for an approximate perceptual gamma of 2.
module led_pwm_bank #(
    parameter int NUM_LEDS    = 8,
    parameter int ADDR_BITS   = 3,
    parameter int PWM_BITS    = 8,
    parameter int TICK_DIV    = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [PWM_BITS+1:0]   wr_data,
    output logic [NUM_LEDS-1:0]   led,
    output logic                  pwm_wrap
);

    localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BC_W = $clog2(BLINK_TICKS + 1);

    localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);
    localparam logic [BC_W-1:0]     BC_LAST  = BC_W'(BLINK_TICKS - 1);
    localparam logic [BC_W-1:0]     BC_ONE   = BC_W'(1);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_PWM     = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    // Shared timebase state
    logic [PWM_BITS-1:0] pwm_cnt_q,     pwm_cnt_d;
    logic                pwm_wrap_q,    pwm_wrap_d;
    logic [PS_W-1:0]     prescaler_q,   prescaler_d;
    logic [BC_W-1:0]     blink_cnt_q,   blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [PWM_BITS-1:0] ramp_q,        ramp_d;
    logic                ramp_fall_q,   ramp_fall_d;

    // Per-channel state
    logic [1:0]          mode_q   [NUM_LEDS];
    logic [1:0]          mode_d   [NUM_LEDS];
    logic [PWM_BITS-1:0] level_q  [NUM_LEDS];
    logic [PWM_BITS-1:0] level_d  [NUM_LEDS];
    logic [PWM_BITS-1:0] active_q [NUM_LEDS];
    logic [PWM_BITS-1:0] active_d [NUM_LEDS];
    logic [NUM_LEDS-1:0] led_q,   led_d;

    logic                  tick;
    logic                  at_max;
    logic [PWM_BITS-1:0]   req_duty   [NUM_LEDS];
    logic [PWM_BITS-1:0]   latch_duty [NUM_LEDS];
    logic [2*PWM_BITS-1:0] breathe_prod [NUM_LEDS];
`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] gamma_prod [NUM_LEDS];
`endif

    assign tick   = (prescaler_q == PS_LAST);
    assign at_max = (pwm_cnt_q == PWM_MAX);

    // Timebase: PWM counter, tick prescaler, blink phase and shared breathe ramp
    always_comb begin
        pwm_cnt_d     = pwm_cnt_q + PWM_ONE;
        pwm_wrap_d    = at_max;
        prescaler_d   = tick ? '0 : prescaler_q + PS_ONE;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        ramp_d        = ramp_q;
        ramp_fall_d   = ramp_fall_q;
        if (tick) begin
            if (blink_cnt_q == BC_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BC_ONE;
            end
            // Triangle wave: the turning points are not repeated, so the
            // sequence goes ...,MAX-1,MAX,MAX-1,... and ...,1,0,1,...
            if (!ramp_fall_q) begin
                if (ramp_q != PWM_MAX) begin
                    ramp_d = ramp_q + PWM_ONE;
                end else begin
                    ramp_d      = PWM_MAX - PWM_ONE;
                    ramp_fall_d = 1'b1;
                end
            end else begin
                if (ramp_q != '0) begin
                    ramp_d = ramp_q - PWM_ONE;
                end else begin
                    ramp_d      = PWM_ONE;
                    ramp_fall_d = 1'b0;
                end
            end
        end
    end

    // Per-channel config writes, duty selection and PWM compare
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_d[i]  = mode_q[i];
            level_d[i] = level_q[i];
            // Compare against every index so that an address beyond
            // NUM_LEDS simply matches no channel.
            if (wr_en && (int'(wr_addr) == i)) begin
                mode_d[i]  = wr_data[PWM_BITS+1:PWM_BITS];
                level_d[i] = wr_data[PWM_BITS-1:0];
            end

            breathe_prod[i] = {{PWM_BITS{1'b0}}, ramp_q} * {{PWM_BITS{1'b0}}, level_q[i]};
            case (mode_q[i])
                MODE_OFF:     req_duty[i] = '0;
                MODE_PWM:     req_duty[i] = level_q[i];
                MODE_BLINK:   req_duty[i] = blink_phase_q ? level_q[i] : '0;
                MODE_BREATHE: req_duty[i] = breathe_prod[i][2*PWM_BITS-1:PWM_BITS];
                default:      req_duty[i] = '0;
            endcase

`ifdef LED_GAMMA_EN
            gamma_prod[i] = {{PWM_BITS{1'b0}}, req_duty[i]} * {{PWM_BITS{1'b0}}, req_duty[i]};
            latch_duty[i] = gamma_prod[i][2*PWM_BITS-1:PWM_BITS];
`else
            latch_duty[i] = req_duty[i];
`endif

            // Duty only changes on the last count of a period, so every
            // period is produced entirely with one duty value.
            active_d[i] = at_max ? latch_duty[i] : active_q[i];
            led_d[i]    = (pwm_cnt_q < active_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q     <= '0;
            pwm_wrap_q    <= 1'b0;
            prescaler_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            ramp_q        <= '0;
            ramp_fall_q   <= 1'b0;
            led_q         <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]   <= MODE_OFF;
                level_q[i]  <= '0;
                active_q[i] <= '0;
            end
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            pwm_wrap_q    <= pwm_wrap_d;
            prescaler_q   <= prescaler_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            ramp_q        <= ramp_d;
            ramp_fall_q   <= ramp_fall_d;
            led_q         <= led_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i]   <= mode_d[i];
                level_q[i]  <= level_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign led      = led_q;
    assign pwm_wrap = pwm_wrap_q;

endmodule
